// File: rtl/squash_unit_l1_chain_pkg.sv
// rtl/squash_unit_l1_chain_pkg.sv - shared widths and message types for the L1 squash arbiter
package squash_unit_l1_chain_pkg;

  localparam int unsigned SEQ_NUM_BITS_DEF = 5;
  localparam int unsigned TARGET_BITS      = 32;
  localparam int unsigned WADDR_BITS       = 5;

  typedef struct packed {
    logic [SEQ_NUM_BITS_DEF-1:0] seq_num;
    logic [TARGET_BITS-1:0]      target;
  } squash_msg_t;

  typedef struct packed {
    logic [TARGET_BITS-1:0]      pc;
    logic [SEQ_NUM_BITS_DEF-1:0] seq_num;
    logic [WADDR_BITS-1:0]       waddr;
    logic [31:0]                 wdata;
    logic                        wen;
  } commit_msg_t;

endpackage

// File: rtl/squash_unit_l1_chain_older_sel.sv
// rtl/squash_unit_l1_chain_older_sel.sv - picks the older of two squash notifications, A wins ties
module squash_older_sel
  import squash_unit_l1_chain_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS_DEF
) (
  input  logic                      a_val_i,
  input  logic [p_seq_num_bits-1:0] a_seq_num_i,
  input  logic [TARGET_BITS-1:0]    a_target_i,
  input  logic                      b_val_i,
  input  logic [p_seq_num_bits-1:0] b_seq_num_i,
  input  logic [TARGET_BITS-1:0]    b_target_i,
  input  logic [p_seq_num_bits-1:0] last_commit_i,
  output logic                      val_o,
  output logic [p_seq_num_bits-1:0] seq_num_o,
  output logic [TARGET_BITS-1:0]    target_o
);

  logic [p_seq_num_bits-1:0] age_a;
  logic [p_seq_num_bits-1:0] age_b;
  logic                      take_b;

  // Distance past the last commit; modular subtraction absorbs wrap-around.
  assign age_a  = a_seq_num_i - last_commit_i - 1'b1;
  assign age_b  = b_seq_num_i - last_commit_i - 1'b1;
  assign take_b = b_val_i && (!a_val_i || (age_b < age_a));

  assign val_o     = a_val_i | b_val_i;
  assign seq_num_o = take_b ? b_seq_num_i : a_seq_num_i;
  assign target_o  = take_b ? b_target_i  : a_target_i;

endmodule

// File: rtl/squash_unit_l1_chain.sv
// rtl/squash_unit_l1_chain.sv - L1 squash arbiter: forwards the oldest squash relative to the commit stream.
// Optional registered grant: SQUASH_UNIT_L1_CHAIN_GNT_REG_EN.
module squash_unit_l1_chain
  import squash_unit_l1_chain_pkg::*;
#(
  parameter int unsigned p_num_arb      = 2,
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [p_num_arb-1:0]                  arb_val_i,
  input  logic [p_num_arb*p_seq_num_bits-1:0]   arb_seq_num_i,
  input  logic [p_num_arb*TARGET_BITS-1:0]      arb_target_i,
  output logic                                  gnt_val_o,
  output logic [p_seq_num_bits-1:0]             gnt_seq_num_o,
  output logic [TARGET_BITS-1:0]                gnt_target_o,
  input  logic                                  commit_val_i,
  input  logic [p_seq_num_bits-1:0]             commit_seq_num_i,
  input  logic [TARGET_BITS-1:0]                commit_pc_i,
  input  logic [WADDR_BITS-1:0]                 commit_waddr_i,
  input  logic [31:0]                           commit_wdata_i,
  input  logic                                  commit_wen_i
);

  logic [p_seq_num_bits-1:0] last_commit_q, last_commit_d;

  logic                      win_val    [p_num_arb];
  logic [p_seq_num_bits-1:0] win_seq    [p_num_arb];
  logic [TARGET_BITS-1:0]    win_target [p_num_arb];

  logic                      sel_val;
  logic [p_seq_num_bits-1:0] sel_seq;
  logic [TARGET_BITS-1:0]    sel_target;

  logic unused_commit_payload;
  assign unused_commit_payload = ^{commit_pc_i, commit_waddr_i, commit_wdata_i, commit_wen_i};

  // All-ones after reset so that sequence number 0 is the oldest possible.
  always_comb begin
    last_commit_d = last_commit_q;
    if (commit_val_i) last_commit_d = commit_seq_num_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_commit_q <= '1;
    else         last_commit_q <= last_commit_d;
  end

  assign win_val[0]    = arb_val_i[0];
  assign win_seq[0]    = arb_seq_num_i[p_seq_num_bits-1:0];
  assign win_target[0] = arb_target_i[TARGET_BITS-1:0];

  for (genvar i = 1; i < p_num_arb; i++) begin : g_chain
    squash_older_sel #(
      .p_seq_num_bits(p_seq_num_bits)
    ) u_sel (
      .a_val_i      (win_val[i-1]),
      .a_seq_num_i  (win_seq[i-1]),
      .a_target_i   (win_target[i-1]),
      .b_val_i      (arb_val_i[i]),
      .b_seq_num_i  (arb_seq_num_i[i*p_seq_num_bits +: p_seq_num_bits]),
      .b_target_i   (arb_target_i[i*TARGET_BITS +: TARGET_BITS]),
      .last_commit_i(last_commit_q),
      .val_o        (win_val[i]),
      .seq_num_o    (win_seq[i]),
      .target_o     (win_target[i])
    );
  end

  // The final stage's payload is zeroed when nothing is valid.
  assign sel_val    = win_val[p_num_arb-1];
  assign sel_seq    = sel_val ? win_seq[p_num_arb-1]    : '0;
  assign sel_target = sel_val ? win_target[p_num_arb-1] : '0;

`ifdef SQUASH_UNIT_L1_CHAIN_GNT_REG_EN
  logic                      gnt_val_q;
  logic [p_seq_num_bits-1:0] gnt_seq_q;
  logic [TARGET_BITS-1:0]    gnt_target_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_val_q    <= 1'b0;
      gnt_seq_q    <= '0;
      gnt_target_q <= '0;
    end else begin
      gnt_val_q    <= sel_val;
      gnt_seq_q    <= sel_seq;
      gnt_target_q <= sel_target;
    end
  end

  assign gnt_val_o     = gnt_val_q;
  assign gnt_seq_num_o = gnt_seq_q;
  assign gnt_target_o  = gnt_target_q;
`else
  assign gnt_val_o     = sel_val;
  assign gnt_seq_num_o = sel_seq;
  assign gnt_target_o  = sel_target;
`endif

endmodule

// File: tb/tb_squash_unit_l1_chain.sv
// tb/tb_squash_unit_l1_chain.sv - self-checking bench over several arbiter widths sharing one stimulus
module tb_squash_unit_l1_chain;

  localparam int NCFG = 6;
  localparam int MAXN = 20;

  function automatic int ns(int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 5;
      4: return 8;
      default: return 20;
    endcase
  endfunction

  logic              clk;
  logic              rst_n;
  logic [MAXN-1:0]   av;
  logic [MAXN*5-1:0] aseq;
  logic [MAXN*32-1:0] atgt;
  logic              cval;
  logic [4:0]        cseq;
  logic [31:0]       cpc;
  logic [4:0]        cwaddr;
  logic [31:0]       cwdata;
  logic              cwen;

  logic        gv [NCFG];
  logic [4:0]  gs [NCFG];
  logic [31:0] gt [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int N = ns(g);
    squash_unit_l1_chain #(
      .p_num_arb(N),
      .p_seq_num_bits(5)
    ) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .arb_val_i       (av[N-1:0]),
      .arb_seq_num_i   (aseq[N*5-1:0]),
      .arb_target_i    (atgt[N*32-1:0]),
      .gnt_val_o       (gv[g]),
      .gnt_seq_num_o   (gs[g]),
      .gnt_target_o    (gt[g]),
      .commit_val_i    (cval),
      .commit_seq_num_i(cseq),
      .commit_pc_i     (cpc),
      .commit_waddr_i  (cwaddr),
      .commit_wdata_i  (cwdata),
      .commit_wen_i    (cwen)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lc = 31;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int age(int s);
    return (s - lc - 1) & 31;
  endfunction

  // Reference: the valid source with the smallest age; first index wins ties.
  task automatic model(input int n, output logic v, output logic [4:0] s, output logic [31:0] t);
    int best = 32;
    int idx = -1;
    for (int i = 0; i < n; i++) begin
      if (av[i] && age(int'(aseq[i*5 +: 5])) < best) begin
        best = age(int'(aseq[i*5 +: 5]));
        idx = i;
      end
    end
    v = (idx >= 0);
    s = v ? aseq[idx*5 +: 5] : 5'd0;
    t = v ? atgt[idx*32 +: 32] : 32'd0;
  endtask

  task automatic check_all(input string tag);
    logic v;
    logic [4:0] s;
    logic [31:0] t;
    for (int g = 0; g < NCFG; g++) begin
      model(ns(g), v, s, t);
      chk($sformatf("%s.n%0d.val", tag, ns(g)), {31'd0, gv[g]}, {31'd0, v});
      chk($sformatf("%s.n%0d.seq", tag, ns(g)), {27'd0, gs[g]}, {27'd0, s});
      chk($sformatf("%s.n%0d.tgt", tag, ns(g)), gt[g], t);
    end
  endtask

  task automatic clear_arbs();
    av = '0;
    aseq = '0;
    atgt = '0;
    cval = 1'b0;
    cseq = 5'd0;
  endtask

  task automatic set_arb(input int i, input logic [4:0] s, input logic [31:0] t);
    av[i] = 1'b1;
    aseq[i*5 +: 5] = s;
    atgt[i*32 +: 32] = t;
  endtask

  // Advance one clock, mirroring the commit register in the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n && cval) lc = int'(cseq);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cpc = 32'h1234_5678;
    cwaddr = 5'd3;
    cwdata = 32'hCAFE_F00D;
    cwen = 1'b1;
    clear_arbs();
    @(negedge clk);
    #2;
    check_all("reset_idle");

    // Grant stays combinational in reset, aged against all-ones.
    set_arb(0, 5'd31, 32'h1);
    set_arb(1, 5'd0, 32'h2);
    #1;
    check_all("reset_mirror");
    chk("reset_mirror.seq0", {27'd0, gs[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_arbs();
    tick();

    set_arb(2, 5'd7, 32'hDEADBEEF);
    #1;
    chk("single.val", {31'd0, gv[2]}, 32'd1);
    chk("single.seq", {27'd0, gs[2]}, 32'd7);
    chk("single.tgt", gt[2], 32'hDEADBEEF);
    check_all("single");

    for (int i = 0; i < MAXN; i++) begin
      clear_arbs();
      set_arb(i, 5'($urandom_range(0, 31)), $urandom);
      #1;
      check_all($sformatf("each%0d", i));
    end

    clear_arbs();
    set_arb(0, 5'd9, 32'h100);
    set_arb(1, 5'd3, 32'h200);
    #1;
    chk("oldest.seq", {27'd0, gs[1]}, 32'd3);
    chk("oldest.tgt", gt[1], 32'h200);

    clear_arbs();
    cval = 1'b1;
    cseq = 5'd28;
    tick();
    clear_arbs();
    set_arb(0, 5'd2, 32'hA);
    set_arb(1, 5'd30, 32'hB);
    #1;
    chk("wrap.seq", {27'd0, gs[1]}, 32'd30);
    chk("wrap.tgt", gt[1], 32'hB);

    clear_arbs();
    set_arb(0, 5'd5, 32'h10);
    set_arb(1, 5'd5, 32'h20);
    #1;
    chk("tie.tgt", gt[1], 32'h10);
    clear_arbs();
    #1;
    chk("none.val", {31'd0, gv[5]}, 32'd0);
    chk("none.seq", {27'd0, gs[5]}, 32'd0);
    chk("none.tgt", gt[5], 32'd0);

    // Same-cycle commit must not affect the current grant.
    @(negedge clk);
    rst_n = 1'b0;
    lc = 31;
    #1;
    rst_n = 1'b1;
    clear_arbs();
    cval = 1'b1;
    cseq = 5'd10;
    set_arb(0, 5'd12, 32'hC);
    set_arb(1, 5'd8, 32'h8);
    #1;
    chk("samecyc.seq", {27'd0, gs[1]}, 32'd8);
    tick();
    cval = 1'b0;
    #1;
    chk("nextcyc.seq", {27'd0, gs[1]}, 32'd12);

    // Async reset restores the all-ones reference immediately.
    clear_arbs();
    cval = 1'b1;
    cseq = 5'd15;
    tick();
    clear_arbs();
    set_arb(0, 5'd16, 32'h16);
    set_arb(1, 5'd0, 32'h0F);
    #1;
    chk("pre_rst.seq", {27'd0, gs[1]}, 32'd16);
    rst_n = 1'b0;
    lc = 31;
    #1;
    chk("async_rst.seq", {27'd0, gs[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++) begin
      clear_arbs();
      for (int i = 0; i < MAXN; i++) begin
        if ($urandom_range(0, 2) == 0)
          set_arb(i, 5'($urandom_range(0, 31)), $urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        av = '0;
        for (int i = 0; i < MAXN; i++) set_arb(i, 5'($urandom_range(4, 6)), $urandom);
      end
      cval = 1'($urandom_range(0, 1));
      cseq = 5'($urandom_range(0, 31));
      #1;
      check_all($sformatf("rand%0d", k));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/squash_unit_l1_chain.md
Name: squash_unit_l1_chain

Overview:
- Level-1 squash arbiter. Collects squash notifications from p_num_arb producers (e.g. functional-unit pipes, branch units).
- Forwards exactly one notification downstream: the one carrying the oldest sequence number.
- Age is computed relative to the commit stream.
- Built as a linear chain of 2-input "keep the older one" selectors. Sits between the execute-side squash producers and the front-end redirect / squash broadcast.

Parameters:
- p_num_arb, 2, number of squash sources (>=1).
- p_seq_num_bits, 5, sequence-number width (>=2); shared by all notif ports.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- arb_val  in  p_num_arb  per-source squash valid.
- arb_seq_num  in  p_num_arb x p_seq_num_bits  per-source squashing instruction's sequence number.
- arb_target  in  p_num_arb x 32  per-source redirect target PC.
- gnt_val  out  1  a squash is granted this cycle.
- gnt_seq_num  out  p_seq_num_bits  granted sequence number.
- gnt_target  out  32  granted target PC.
- commit_val  in  1  an instruction commits this cycle.
- commit_seq_num  in  p_seq_num_bits  sequence number of the committing instruction.
- commit_pc, commit_waddr(5), commit_wdata(32), commit_wen(1)  in  commit payload. Accepted and ignored.

Behaviour:
- Notifications are valid-only: no ready, no backpressure, no buffering. A notif exists only in the cycle its val is high.
- Grant path is purely combinational, zero latency: gnt_* reflect the same-cycle arb_* inputs.
- gnt_val = OR of all arb_val.
- When gnt_val=0: gnt_seq_num=0, gnt_target=0.
- Age reference:
  - Register last_commit (p_seq_num_bits).
  - On reset it is set to all-ones, so seq 0 is the oldest possible.
  - On each clk rising edge with commit_val=1, last_commit <= commit_seq_num.
- Age of sequence number s: age(s) = (s - last_commit - 1) mod 2^p_seq_num_bits. Smaller age = older. Wrap-around is handled by the modular subtraction.
- Comparisons always use the registered last_commit. A commit arriving in the same cycle as squashes affects only later cycles.
- Chain selection:
  - Stage 0 takes source 0.
  - Stage i replaces the running winner with source i iff arb_val[i] and (running winner invalid, or age(seq_i) < age(winner)).
  - The final stage drives gnt.
- Ties (equal seq numbers or equal age): the lower source index wins, since strict less-than never replaces it.
- p_num_arb=1: pure pass-through of source 0.
- Reset asserted: last_commit returns to all-ones immediately. The grant path stays combinational, so gnt still mirrors arb inputs during reset.
- No other state.

Optional Feature:
- Macro SQUASH_UNIT_L1_CHAIN_GNT_REG_EN.
- When defined: gnt_val/gnt_seq_num/gnt_target are registered, giving 1-cycle latency. The register resets to 0 (gnt_val=0) asynchronously.
- Age comparison still uses last_commit as of the input cycle.
- When undefined: combinational grant as above.

Decomposition:
- Shared package: seq-num width default, squash message struct {seq_num, target[31:0]}, commit message struct {pc, seq_num, waddr, wdata, wen}.
- Natural sub-module: squash_older_sel. Inputs: two {val, seq_num, target} plus last_commit. Output: the older valid one, preferring input A on tie. It is instantiated p_num_arb-1 times in the chain.
- The last_commit tracker stays inline.

Test Plan:
- Single source: p_num_arb=4, only arb 2 valid with seq 7, target 0xDEADBEEF -> same cycle gnt_val=1, seq 7, target 0xDEADBEEF.
- Every source in turn: each arb i alone with random seq/target, for each p_num_arb in {1,2,4,5,8,20} -> grant equals that input, zero latency.
- Oldest wins: after reset (last_commit=31, 5 bits), arb0 seq 9/0x100, arb1 seq 3/0x200 -> gnt seq 3, target 0x200.
- Wrap-around: commit seq 28, next cycle arb0 seq 2/0xA, arb1 seq 30/0xB -> gnt seq 30, target 0xB, since 30 is older past the wrap.
- Tie: arb0 and arb1 both seq 5 with targets 0x10/0x20 -> gnt target 0x10; no valid inputs -> gnt_val=0, seq 0, target 0.
- Same-cycle commit: commit seq 10 and arb0 seq 12, arb1 seq 8 in the same cycle after reset -> gnt seq 8. The next cycle with the same arbs -> gnt seq 12.
